// File: rtl/gpu_mem_pkg.sv
// Shared memory-side types and default widths for the LSUs, arbiter and gpu top.
package gpu_mem_pkg;

    localparam int unsigned DEF_ADDR_BITS = 8;
    localparam int unsigned DEF_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        RELAYING
    } mem_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping modulo NUM.
module rr_pick #(
    parameter int unsigned NUM   = 4,
    parameter int unsigned PTR_W = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [NUM-1:0]   i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_found,
    output logic [PTR_W-1:0] o_winner
);

    int unsigned      w_idx;
    logic [PTR_W-1:0] w_sel;

    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        w_sel    = '0;
        for (int k = 0; k < int'(NUM); k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM) begin
                w_idx = w_idx - NUM;
            end
            w_sel = PTR_W'(w_idx);
            if (!o_found && i_req[w_sel]) begin
                o_found  = 1'b1;
                o_winner = w_sel;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel among NUM_CONSUMERS requesters,
// one transaction at a time, with fully registered outputs.
module mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
    parameter int unsigned DATA_BITS     = DEF_DATA_BITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);

    localparam int unsigned PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    mem_arb_state_t     r_state, w_state_next;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_next;
    logic [PTR_W-1:0]   r_id, w_id_next;
    logic [ADDR_BITS-1:0] r_addr, w_addr_next;
    logic [DATA_BITS-1:0] r_wdata, w_wdata_next;
    logic               r_mem_rv, w_mem_rv_next;
    logic               r_mem_wv, w_mem_wv_next;
    logic [NUM_CONSUMERS-1:0] r_rready, w_rready_next;
    logic [NUM_CONSUMERS-1:0] r_wready, w_wready_next;
    logic [DATA_BITS-1:0] r_rdata [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] w_rdata_next [NUM_CONSUMERS];

    logic [ADDR_BITS-1:0] w_rd_addr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] w_wr_addr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] w_wr_data [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] w_req;
    logic                 w_found;
    logic [PTR_W-1:0]     w_winner;
    logic                 w_served_valid;

    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_slice
        assign w_rd_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign w_wr_addr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        assign w_wr_data[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = r_rdata[i];
    end

    assign w_req = consumer_read_valid | consumer_write_valid;

    rr_pick #(
        .NUM   (NUM_CONSUMERS),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req    (w_req),
        .i_ptr    (r_rr_ptr),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    // Only the direction that was served gates the release; the other stays pending.
    assign w_served_valid = (|r_rready) ? consumer_read_valid[r_id] : consumer_write_valid[r_id];

    always_comb begin
        w_state_next  = r_state;
        w_rr_ptr_next = r_rr_ptr;
        w_id_next     = r_id;
        w_addr_next   = r_addr;
        w_wdata_next  = r_wdata;
        w_mem_rv_next = r_mem_rv;
        w_mem_wv_next = r_mem_wv;
        w_rready_next = r_rready;
        w_wready_next = r_wready;
        w_rdata_next  = r_rdata;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_id_next    = w_winner;
                    w_wdata_next = w_wr_data[w_winner];
                    if (consumer_read_valid[w_winner]) begin
                        w_addr_next   = w_rd_addr[w_winner];
                        w_mem_rv_next = 1'b1;
                        w_state_next  = READ_WAITING;
                    end else begin
                        w_addr_next   = w_wr_addr[w_winner];
                        w_mem_wv_next = 1'b1;
                        w_state_next  = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    w_mem_rv_next       = 1'b0;
                    w_rdata_next[r_id]  = mem_read_data;
                    w_rready_next[r_id] = 1'b1;
                    w_state_next        = RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    w_mem_wv_next       = 1'b0;
                    w_wready_next[r_id] = 1'b1;
                    w_state_next        = RELAYING;
                end
            end
            RELAYING: begin
                if (!w_served_valid) begin
                    w_rready_next = '0;
                    w_wready_next = '0;
                    w_rr_ptr_next = (int'(r_id) == int'(NUM_CONSUMERS) - 1) ? '0
                                                                            : r_id + PTR_W'(1);
                    w_state_next  = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_mem_rv <= 1'b0;
            r_mem_wv <= 1'b0;
            r_rready <= '0;
            r_wready <= '0;
            r_rdata  <= '{default: '0};
        end else begin
            r_state  <= w_state_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_id     <= w_id_next;
            r_addr   <= w_addr_next;
            r_wdata  <= w_wdata_next;
            r_mem_rv <= w_mem_rv_next;
            r_mem_wv <= w_mem_wv_next;
            r_rready <= w_rready_next;
            r_wready <= w_wready_next;
            r_rdata  <= w_rdata_next;
        end
    end

    assign consumer_read_ready  = r_rready;
    assign consumer_write_ready = r_wready;
    assign mem_read_valid       = r_mem_rv;
    assign mem_write_valid      = r_mem_wv;
    assign mem_read_address     = r_addr;
    assign mem_write_address    = r_addr;
    assign mem_write_data       = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four requesters, 8-bit address and data.
module tb_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC-1:0]    consumer_read_valid;
    logic [NC*AW-1:0] consumer_read_address;
    logic [NC-1:0]    consumer_read_ready;
    logic [NC*DW-1:0] consumer_read_data;
    logic [NC-1:0]    consumer_write_valid;
    logic [NC*AW-1:0] consumer_write_address;
    logic [NC*DW-1:0] consumer_write_data;
    logic [NC-1:0]    consumer_write_ready;
    logic             mem_read_valid;
    logic [AW-1:0]    mem_read_address;
    logic             mem_read_ready;
    logic [DW-1:0]    mem_read_data;
    logic             mem_write_valid;
    logic [AW-1:0]    mem_write_address;
    logic [DW-1:0]    mem_write_data;
    logic             mem_write_ready;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(
        .NUM_CONSUMERS (NC),
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = 1'b0;
        mem_read_data          = '0;
        mem_write_ready        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rd_slice(input int i);
        return consumer_read_data[i*DW +: DW];
    endfunction

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rv=%b wv=%b rr=%b wr=%b, want all 0",
                     mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready);
        end
        n_vec++;
        if ({consumer_read_data, mem_read_address, mem_write_address, mem_write_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got rdata=%h ra=%h wa=%h wd=%h, want all 0",
                     consumer_read_data, mem_read_address, mem_write_address, mem_write_data);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        consumer_read_valid[2]              = 1'b1;
        consumer_read_address[2*AW +: AW]   = 8'h10;
        tick();
        n_vec++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h10) begin
            n_err++;
            $display("FAIL single_req: got rv=%b addr=%h, want rv=1 addr=10",
                     mem_read_valid, mem_read_address);
        end
        tick();
        tick();
        n_vec++;
        if (mem_read_valid !== 1'b1 || consumer_read_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL single_hold: got rv=%b rready=%b, want rv=1 rready=0000",
                     mem_read_valid, consumer_read_ready);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 8'hAB;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = 8'h00;
        n_vec++;
        if (consumer_read_ready !== 4'b0100 || rd_slice(2) !== 8'hAB || mem_read_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_resp: got rready=%b data=%h rv=%b, want 0100 AB 0",
                     consumer_read_ready, rd_slice(2), mem_read_valid);
        end
        tick();
        n_vec++;
        if (consumer_read_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL single_relay_hold: got rready=%b, want 0100", consumer_read_ready);
        end
        consumer_read_valid[2] = 1'b0;
        tick();
        n_vec++;
        if (consumer_read_ready !== 4'b0000 || rd_slice(2) !== 8'hAB) begin
            n_err++;
            $display("FAIL single_release: got rready=%b data=%h, want 0000 AB",
                     consumer_read_ready, rd_slice(2));
        end
    endtask

    task automatic test_round_robin();
        logic [NC-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < NC; i++) begin
            consumer_read_address[i*AW +: AW] = 8'(8'h20 + i);
        end
        consumer_read_valid = 4'b1111;
        for (int k = 0; k < NC; k++) begin
            tick();
            n_vec++;
            if (mem_read_valid !== 1'b1 || mem_read_address !== 8'(8'h20 + k)) begin
                n_err++;
                $display("FAIL rr_grant%0d: got rv=%b addr=%h, want rv=1 addr=%h",
                         k, mem_read_valid, mem_read_address, 8'(8'h20 + k));
            end
            if (k == 3) begin
                consumer_read_valid[0]     = 1'b1;
                consumer_read_address[0 +: AW] = 8'h30;
            end
            mem_read_ready = 1'b1;
            mem_read_data  = 8'(8'hC0 + k);
            tick();
            mem_read_ready = 1'b0;
            exp_rdy = '0;
            exp_rdy[k] = 1'b1;
            n_vec++;
            if (consumer_read_ready !== exp_rdy || rd_slice(k) !== 8'(8'hC0 + k)) begin
                n_err++;
                $display("FAIL rr_resp%0d: got rready=%b data=%h, want %b %h",
                         k, consumer_read_ready, rd_slice(k), exp_rdy, 8'(8'hC0 + k));
            end
            consumer_read_valid[k] = 1'b0;
            tick();
        end
        tick();
        n_vec++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h30) begin
            n_err++;
            $display("FAIL rr_wrap: got rv=%b addr=%h, want rv=1 addr=30",
                     mem_read_valid, mem_read_address);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 8'h3C;
        tick();
        mem_read_ready = 1'b0;
        consumer_read_valid[0] = 1'b0;
        tick();
        n_vec++;
        if (consumer_read_ready !== 4'b0000 || rd_slice(0) !== 8'h3C || rd_slice(1) !== 8'hC1) begin
            n_err++;
            $display("FAIL rr_final: got rready=%b d0=%h d1=%h, want 0000 3C C1",
                     consumer_read_ready, rd_slice(0), rd_slice(1));
        end
    endtask

    task automatic test_rw_priority();
        do_reset();
        consumer_read_valid[1]             = 1'b1;
        consumer_read_address[1*AW +: AW]  = 8'h05;
        consumer_write_valid[1]            = 1'b1;
        consumer_write_address[1*AW +: AW] = 8'h06;
        consumer_write_data[1*DW +: DW]    = 8'h77;
        tick();
        n_vec++;
        if (mem_read_valid !== 1'b1 || mem_write_valid !== 1'b0 || mem_read_address !== 8'h05) begin
            n_err++;
            $display("FAIL prio_read_first: got rv=%b wv=%b addr=%h, want 1 0 05",
                     mem_read_valid, mem_write_valid, mem_read_address);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 8'h5A;
        tick();
        mem_read_ready = 1'b0;
        n_vec++;
        if (consumer_read_ready !== 4'b0010 || consumer_write_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL prio_read_done: got rready=%b wready=%b, want 0010 0000",
                     consumer_read_ready, consumer_write_ready);
        end
        consumer_read_valid[1] = 1'b0;
        tick();
        tick();
        n_vec++;
        if (mem_write_valid !== 1'b1 || mem_read_valid !== 1'b0 || mem_write_address !== 8'h06 ||
            mem_write_data !== 8'h77) begin
            n_err++;
            $display("FAIL prio_write_grant: got wv=%b rv=%b addr=%h data=%h, want 1 0 06 77",
                     mem_write_valid, mem_read_valid, mem_write_address, mem_write_data);
        end
        mem_read_ready = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        n_vec++;
        if (mem_write_valid !== 1'b1 || consumer_write_ready !== 4'b0000 ||
            consumer_read_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL prio_wrong_dir: got wv=%b wready=%b rready=%b, want 1 0000 0000",
                     mem_write_valid, consumer_write_ready, consumer_read_ready);
        end
        mem_write_ready = 1'b1;
        tick();
        mem_write_ready = 1'b0;
        n_vec++;
        if (consumer_write_ready !== 4'b0010 || mem_write_valid !== 1'b0 || rd_slice(1) !== 8'h5A) begin
            n_err++;
            $display("FAIL prio_write_done: got wready=%b wv=%b d1=%h, want 0010 0 5A",
                     consumer_write_ready, mem_write_valid, rd_slice(1));
        end
        consumer_write_valid[1] = 1'b0;
        tick();
        n_vec++;
        if (consumer_write_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL prio_write_release: got wready=%b, want 0000", consumer_write_ready);
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        consumer_read_valid[0]         = 1'b1;
        consumer_read_address[0 +: AW] = 8'h40;
        tick();
        consumer_read_valid[0]         = 1'b0;
        consumer_read_address[0 +: AW] = 8'h41;
        tick();
        n_vec++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h40) begin
            n_err++;
            $display("FAIL drop_wait: got rv=%b addr=%h, want 1 40", mem_read_valid, mem_read_address);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 8'h99;
        tick();
        mem_read_ready = 1'b0;
        n_vec++;
        if (consumer_read_ready !== 4'b0001 || rd_slice(0) !== 8'h99) begin
            n_err++;
            $display("FAIL drop_resp: got rready=%b data=%h, want 0001 99",
                     consumer_read_ready, rd_slice(0));
        end
        consumer_read_valid[3]          = 1'b1;
        consumer_read_address[3*AW +: AW] = 8'h4F;
        tick();
        n_vec++;
        if (consumer_read_ready !== 4'b0000 || mem_read_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drop_pulse: got rready=%b rv=%b, want 0000 0",
                     consumer_read_ready, mem_read_valid);
        end
        tick();
        n_vec++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h4F) begin
            n_err++;
            $display("FAIL drop_idle_next: got rv=%b addr=%h, want 1 4F",
                     mem_read_valid, mem_read_address);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        consumer_write_valid[1]            = 1'b1;
        consumer_write_address[1*AW +: AW] = 8'h33;
        consumer_write_data[1*DW +: DW]    = 8'h44;
        tick();
        n_vec++;
        if (mem_write_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: got wv=%b, want 1", mem_write_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (mem_write_valid !== 1'b0 || consumer_write_ready !== '0 || consumer_read_ready !== '0 ||
            mem_write_address !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_async: got wv=%b wready=%b rready=%b wa=%h, want 0 0000 0000 00",
                     mem_write_valid, consumer_write_ready, consumer_read_ready, mem_write_address);
        end
        #1;
        reset = 1'b0;
        clear_inputs();
        consumer_write_valid[3]            = 1'b1;
        consumer_write_address[3*AW +: AW] = 8'h3A;
        consumer_write_data[3*DW +: DW]    = 8'h5C;
        tick();
        n_vec++;
        if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h3A || mem_write_data !== 8'h5C) begin
            n_err++;
            $display("FAIL midrst_regrant: got wv=%b addr=%h data=%h, want 1 3A 5C",
                     mem_write_valid, mem_write_address, mem_write_data);
        end
        mem_write_ready = 1'b1;
        tick();
        mem_write_ready = 1'b0;
        n_vec++;
        if (consumer_write_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_done: got wready=%b, want 1000", consumer_write_ready);
        end
        consumer_write_valid[3] = 1'b0;
        tick();
    endtask

    task automatic test_stray_ready();
        do_reset();
        tick();
        mem_read_ready  = 1'b1;
        mem_read_data   = 8'hEE;
        mem_write_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready} !== '0 ||
            consumer_read_data !== '0) begin
            n_err++;
            $display("FAIL stray_idle: got rv=%b wv=%b rr=%b wr=%b rdata=%h, want all 0",
                     mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready,
                     consumer_read_data);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_rw_priority();
        test_early_drop();
        test_reset_mid_write();
        test_stray_ready();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one data-memory channel between NUM_CONSUMERS requesters, such as per-thread LSUs across the cores.
- Grants requesters round-robin and serves one transaction at a time.
- Latches the granted request and drives the memory-side valid/ready handshake.
- Returns read data to the winner, then holds ready until the requester releases its valid.
- Sits between the cores' LSUs and the external data memory port of the gpu top.

Parameters:
- NUM_CONSUMERS, 4, number of requesters (>=1).
- ADDR_BITS, 8, address width.
- DATA_BITS, 8, data width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- consumer_read_valid  in  NUM_CONSUMERS  per-requester read request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; slice i belongs to requester i.
- consumer_read_ready  out  NUM_CONSUMERS  read complete, held until valid drops.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed; returned read data.
- consumer_write_valid  in  NUM_CONSUMERS  per-requester write request.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed.
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed.
- consumer_write_ready  out  NUM_CONSUMERS  write complete, held until valid drops.
- mem_read_valid  out  1  read request to memory.
- mem_read_address  out  ADDR_BITS.
- mem_read_ready  in  1  memory read done; mem_read_data valid this cycle.
- mem_read_data  in  DATA_BITS.
- mem_write_valid  out  1  write request to memory.
- mem_write_address  out  ADDR_BITS.
- mem_write_data  out  DATA_BITS.
- mem_write_ready  in  1  memory write done.

Behaviour:
- Single clock clk. reset is asynchronous and active-high.
- On reset:
  - all outputs are 0;
  - state=IDLE, rr_ptr=0, granted id=0;
  - any in-flight memory transaction is abandoned, with no cleanup.
- All outputs are registered.
- States are IDLE, READ_WAITING, WRITE_WAITING, RELAYING.
- IDLE:
  - Scan requesters rr_ptr, rr_ptr+1, ... wrapping mod NUM_CONSUMERS.
  - The first requester with read_valid or write_valid wins.
  - If a winner asserts both, read has priority; its write is served on a later grant.
  - On a grant in cycle t: latch id, address and write data; at t+1 mem_read_valid=1 (-> READ_WAITING) or mem_write_valid=1 (-> WRITE_WAITING).
  - No request: stay in IDLE.
- READ_WAITING:
  - mem_read_valid and mem_read_address are held stable.
  - On mem_read_ready at cycle u: at u+1 mem_read_valid=0, consumer_read_data[id]=mem_read_data sampled at u, consumer_read_ready[id]=1 -> RELAYING.
- WRITE_WAITING:
  - Same as READ_WAITING, using mem_write_ready and consumer_write_ready[id]; no data is returned.
- RELAYING:
  - Hold ready[id] until read_valid[id] and write_valid[id] (whichever was served) are sampled low at cycle v.
  - At v+1: ready[id]=0, rr_ptr=(id+1) mod NUM_CONSUMERS -> IDLE.
- Latency:
  - Request to mem valid: 1 cycle.
  - Mem ready to consumer ready: 1 cycle.
  - Minimum back-to-back gap: valid-drop sampled at v gives the next mem valid no earlier than v+2.
- consumer_read_data[id] keeps its last value after RELAYING until overwritten by that requester's next read. Other slices never change.
- Boundary conditions:
  - mem_*_ready while IDLE or RELAYING, or the wrong-direction ready: ignored.
  - Requester drops valid during WAITING: the transaction still completes; ready pulses for 1 cycle, then IDLE.
  - Requester changes its address while granted: ignored, because the address is latched.
  - rr_ptr wraps from NUM_CONSUMERS-1 to 0.
  - NUM_CONSUMERS=1: rr_ptr stays 0.
- At most one bit of consumer_read_ready|consumer_write_ready is set at any time.
- mem_read_valid and mem_write_valid are never both 1.

Decomposition:
- Shared package gpu_mem_pkg:
  - mem_arb_state_t enum (IDLE, READ_WAITING, WRITE_WAITING, RELAYING);
  - default ADDR_BITS/DATA_BITS constants, shared with the LSU and gpu top.
- Sub-module rr_pick: combinational, inputs request vector and rr_ptr; outputs found and winner index.
- Reuse rr_pick in the later multi-channel version.

Test Plan:
- Single read: consumer 2 reads addr 0x10, mem returns 0xAB with 3-cycle latency -> mem_read_valid 1 cycle after request; read_ready[2]=1 and data[2]=0xAB 1 cycle after mem ready; ready drops 1 cycle after valid drops.
- Round-robin: all 4 consumers request reads at once from reset -> serviced order 0,1,2,3; consumer 0 re-requests during 3's turn -> served after 3.
- Read/write priority: consumer 1 asserts read 0x05 and write 0x06/0x77 together -> read first, then write on a later grant; mem_write_data=0x77.
- Early valid drop: consumer 0 drops read_valid during READ_WAITING -> transaction completes, read_ready[0] high for exactly 1 cycle, state IDLE next.
- Reset mid-WRITE_WAITING: async reset asserted between clock edges -> mem_write_valid and all ready bits go 0 immediately; after release, rr_ptr=0 and the next request from consumer 3 is granted.
- Stray memory ready: mem_read_ready pulsed in IDLE -> no output change.
